mac_8bitx4_driver: RTL

Operand-side driver for the 4-lane signed 8-bit dot-product MAC hard block (18-bit result). Accepts a valid/ready stream of 4-lane operand pairs and registers them onto the MAC operand ports. Tracks in-flight beats with a tag pipeline matched to the MAC latency and accumulates MAC results into a wide accumulator. Emits one accumulated sum per group, with the group end marked by in_last, through a small output FIFO with valid/ready.

---
 rtl/mac_driver_pkg.sv | 21 ++
 rtl/mac_driver_out_fifo.sv | 45 ++++
 rtl/mac_8bitx4_driver.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mac_driver_pkg.sv
// Shared types and helpers for the 4-lane int8 MAC operand driver.
package mac_driver_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int MAC_RES_W = 18;

    typedef struct packed {
        logic v;
        logic last;
    } tag_t;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/mac_driver_out_fifo.sv
// Group-sum output FIFO: synchronous, head shown as 0 when empty.
module mac_driver_out_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (i_pop) r_rd <= r_rd + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_data  = (r_cnt != '0) ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;

endmodule

// File: rtl/mac_8bitx4_driver.sv
// Operand driver + group accumulator for the 4-lane int8 dot-product MAC.
// Define MAC_DRIVER_SATURATE_EN for saturating (sticky) accumulation.
module mac_8bitx4_driver
    import mac_driver_pkg::*;
#(
    parameter int MAC_LATENCY = 2,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                 clock0,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    input  logic                 in_last,
    output logic [7:0]           mac_dataa_0,
    output logic [7:0]           mac_dataa_1,
    output logic [7:0]           mac_dataa_2,
    output logic [7:0]           mac_dataa_3,
    output logic [7:0]           mac_datab_0,
    output logic [7:0]           mac_datab_1,
    output logic [7:0]           mac_datab_2,
    output logic [7:0]           mac_datab_3,
    input  logic [MAC_RES_W-1:0] mac_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data
);

    localparam int CW = $clog2(OUT_DEPTH) + 1;
    localparam int OW = NUM_LANES * LANE_W;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(OUT_DEPTH);

    logic [OW-1:0]               r_a;
    logic [OW-1:0]               r_b;
    tag_t                        r_tag [MAC_LATENCY+1];
    logic [CW-1:0]               r_pend;
    logic                        r_rdy_en;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_res_ext;
    logic [CW-1:0]               w_cnt;
    tag_t                        w_exit;
    logic                        w_acc;
    logic                        w_inc;
    logic                        w_push;
    logic                        w_pop;

    assign w_acc    = in_valid & in_ready;
    assign w_inc    = w_acc & in_last;
    assign in_ready = r_rdy_en & (({1'b0, w_cnt} + {1'b0, r_pend}) < DEPTH_V);

    assign mac_dataa_0 = r_a[0*LANE_W +: LANE_W];
    assign mac_dataa_1 = r_a[1*LANE_W +: LANE_W];
    assign mac_dataa_2 = r_a[2*LANE_W +: LANE_W];
    assign mac_dataa_3 = r_a[3*LANE_W +: LANE_W];
    assign mac_datab_0 = r_b[0*LANE_W +: LANE_W];
    assign mac_datab_1 = r_b[1*LANE_W +: LANE_W];
    assign mac_datab_2 = r_b[2*LANE_W +: LANE_W];
    assign mac_datab_3 = r_b[3*LANE_W +: LANE_W];

    // Idle cycles drive zero operands so the MAC sees no stale data.
    always_ff @(posedge clock0 or negedge resetn) begin
        if (!resetn) begin
            r_a <= '0;
            r_b <= '0;
            for (int i = 0; i <= MAC_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_a      <= w_acc ? in_a : '0;
            r_b      <= w_acc ? in_b : '0;
            r_tag[0] <= '{v: w_acc, last: w_inc};
            for (int i = 1; i <= MAC_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign w_exit    = r_tag[MAC_LATENCY];
    assign w_push    = w_exit.v & w_exit.last;
    assign w_res_ext = ACC_WIDTH'($signed(mac_result));

    // Pending group ends reserve FIFO slots so a push never finds it full.
    always_ff @(posedge clock0 or negedge resetn) begin
        if (!resetn) begin
            r_pend   <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            case ({w_inc, w_push})
                2'b10:   r_pend <= r_pend + 1'b1;
                2'b01:   r_pend <= r_pend - 1'b1;
                default: r_pend <= r_pend;
            endcase
        end
    end

`ifdef MAC_DRIVER_SATURATE_EN
    localparam logic signed [ACC_WIDTH:0] SMAX = (ACC_WIDTH + 1)'(sat_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH:0] SMIN = (ACC_WIDTH + 1)'(sat_min(ACC_WIDTH));

    logic                      r_sat;
    logic                      w_clip;
    logic signed [ACC_WIDTH:0] w_wide;

    always_comb begin
        w_wide = (ACC_WIDTH + 1)'(r_acc) + (ACC_WIDTH + 1)'(w_res_ext);
        w_sum  = w_wide[ACC_WIDTH-1:0];
        w_clip = 1'b0;
        if (r_sat) begin
            w_sum = r_acc;
        end else if (w_wide > SMAX) begin
            w_sum  = SMAX[ACC_WIDTH-1:0];
            w_clip = 1'b1;
        end else if (w_wide < SMIN) begin
            w_sum  = SMIN[ACC_WIDTH-1:0];
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge clock0 or negedge resetn) begin
        if (!resetn)       r_sat <= 1'b0;
        else if (w_exit.v) r_sat <= w_exit.last ? 1'b0 : (r_sat | w_clip);
    end
`else
    assign w_sum = r_acc + w_res_ext;
`endif

    always_ff @(posedge clock0 or negedge resetn) begin
        if (!resetn)       r_acc <= '0;
        else if (w_exit.v) r_acc <= w_exit.last ? '0 : w_sum;
    end

    assign out_valid = (w_cnt != '0);
    assign w_pop     = out_valid & out_ready;

    mac_driver_out_fifo #(
        .W     (ACC_WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .i_clk   (clock0),
        .i_rst_n (resetn),
        .i_push  (w_push),
        .i_data  (w_sum),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_count (w_cnt)
    );

endmodule
